// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: key codes, ALU op encodings,
// sequencer states and default operand geometry.
package calc_pkg;

    localparam int DEF_INT_DIGITS  = 6;
    localparam int DEF_FRAC_DIGITS = 6;

    localparam logic [4:0] KEY_DOT = 5'd10;
    localparam logic [4:0] KEY_ADD = 5'd11;
    localparam logic [4:0] KEY_SUB = 5'd12;
    localparam logic [4:0] KEY_MUL = 5'd13;
    localparam logic [4:0] KEY_DIV = 5'd14;
    localparam logic [4:0] KEY_EQ  = 5'd15;
    localparam logic [4:0] KEY_CLR = 5'd16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011
    } op_t;

    typedef enum logic [2:0] {
        ENTRY_INT,
        ENTRY_FRAC,
        OP_WAIT,
        RESULT,
        ISSUE,
        GAP,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_INT,
        CMD_FRAC
    } entry_cmd_t;

    function automatic op_t key_to_op(input logic [4:0] code);
        case (code)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_DIV: return OP_DIV;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/key_entry_if.sv
// Keypad-in / ALU-out signal bundle of the key_entry sequencer.
interface key_entry_if #(
    parameter int W = 48
);
    logic         key_valid;
    logic [4:0]   key_code;
    logic         key_ready;
    logic         overflow;
    logic [W-1:0] in_bcd;
    logic [2:0]   op;
    logic         en;
    logic         alu_rst;
    logic [W-1:0] entry_bcd;
    logic         disp_acc;
    logic         err;

    modport master (
        output key_valid, key_code, overflow,
        input  key_ready, in_bcd, op, en, alu_rst, entry_bcd, disp_acc, err
    );

    modport slave (
        input  key_valid, key_code, overflow,
        output key_ready, in_bcd, op, en, alu_rst, entry_bcd, disp_acc, err
    );
endinterface

// File: rtl/bcd_entry_reg.sv
// Operand being typed: integer nibbles shift in from the right, fraction nibbles
// fill from the binary point downwards; extra digits are dropped.
module bcd_entry_reg
    import calc_pkg::*;
#(
    parameter int INT_DIGITS  = DEF_INT_DIGITS,
    parameter int FRAC_DIGITS = DEF_FRAC_DIGITS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  entry_cmd_t                             cmd,
    input  logic [3:0]                             digit,
    output logic [4*(INT_DIGITS+FRAC_DIGITS)-1:0]  entry
);
    localparam int W   = 4 * (INT_DIGITS + FRAC_DIGITS);
    localparam int FW  = 4 * FRAC_DIGITS;
    localparam int ICW = $clog2(INT_DIGITS + 1);
    localparam int FCW = $clog2(FRAC_DIGITS + 1);

    logic [ICW-1:0] ic;
    logic [FCW-1:0] fc;

    always_ff @(posedge clk) begin
        if (rst || cmd == CMD_CLEAR) begin
            entry <= '0;
            ic    <= '0;
            fc    <= '0;
        end else begin
            case (cmd)
                CMD_INT: begin
                    // Leading zeros consume a slot just like any other digit.
                    if (ic < ICW'(INT_DIGITS)) begin
                        entry[W-1:FW] <= {entry[W-5:FW], digit};
                        ic            <= ic + 1'b1;
                    end
                end
                CMD_FRAC: begin
                    if (fc < FCW'(FRAC_DIGITS)) begin
                        for (int i = 0; i < FRAC_DIGITS; i++) begin
                            if (fc == FCW'(FRAC_DIGITS - 1 - i))
                                entry[4*i +: 4] <= digit;
                        end
                        fc <= fc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/key_entry.sv
// Keypad sequencer: builds BCD operands from key strokes and issues them to the
// ALU with chained-operation, divide-by-zero and overflow handling.
module key_entry
    import calc_pkg::*;
#(
    parameter int INT_DIGITS  = DEF_INT_DIGITS,
    parameter int FRAC_DIGITS = DEF_FRAC_DIGITS
) (
    input  logic        clk,
    input  logic        rst,
    key_entry_if.slave  bus
);
    localparam int W = 4 * (INT_DIGITS + FRAC_DIGITS);

    state_t       state, state_n;
    state_t       ret_state, ret_state_n;
    op_t          pending, pending_n;
    op_t          op_q, op_n;
    logic [W-1:0] in_bcd_q, in_bcd_n;
    logic         disp_q, disp_n;
    logic         alu_rst_q, alu_rst_n;
    entry_cmd_t   cmd;
    logic [W-1:0] entry;

    logic accept, is_digit, is_dot, is_opkey, is_eq, is_clr, in_entry;

    bcd_entry_reg #(
        .INT_DIGITS (INT_DIGITS),
        .FRAC_DIGITS(FRAC_DIGITS)
    ) u_entry (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd),
        .digit(bus.key_code[3:0]),
        .entry(entry)
    );

    assign bus.key_ready = (state != ISSUE) && (state != GAP);
    assign accept        = bus.key_valid && bus.key_ready;
    assign is_digit      = bus.key_code <= 5'd9;
    assign is_dot        = bus.key_code == KEY_DOT;
    assign is_opkey      = (bus.key_code >= KEY_ADD) && (bus.key_code <= KEY_DIV);
    assign is_eq         = bus.key_code == KEY_EQ;
    assign is_clr        = bus.key_code == KEY_CLR;
    assign in_entry      = (state == ENTRY_INT) || (state == ENTRY_FRAC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENTRY_INT;
            ret_state <= OP_WAIT;
            pending   <= OP_ADD;
            op_q      <= OP_ADD;
            in_bcd_q  <= '0;
            disp_q    <= 1'b0;
            alu_rst_q <= 1'b0;
        end else begin
            state     <= state_n;
            ret_state <= ret_state_n;
            pending   <= pending_n;
            op_q      <= op_n;
            in_bcd_q  <= in_bcd_n;
            disp_q    <= disp_n;
            alu_rst_q <= alu_rst_n;
        end
    end

    always_comb begin
        state_n     = state;
        ret_state_n = ret_state;
        pending_n   = pending;
        op_n        = op_q;
        in_bcd_n    = in_bcd_q;
        disp_n      = disp_q;
        alu_rst_n   = 1'b0;
        cmd         = CMD_NONE;

        if (state == ISSUE) begin
            state_n = GAP;
        end else if (state == GAP) begin
            // The accumulator has just updated; overflow is only meaningful now.
            state_n = bus.overflow ? ERR : ret_state;
        end else if (accept && is_clr) begin
            alu_rst_n = 1'b1;
            cmd       = CMD_CLEAR;
            pending_n = OP_ADD;
            disp_n    = 1'b0;
            state_n   = ENTRY_INT;
        end else if (accept && in_entry && (is_opkey || is_eq)) begin
            if (pending == OP_DIV && entry == '0) begin
                state_n = ERR;
            end else begin
                in_bcd_n    = entry;
                op_n        = pending;
                pending_n   = is_eq ? OP_ADD : key_to_op(bus.key_code);
                ret_state_n = is_eq ? RESULT : OP_WAIT;
                disp_n      = 1'b1;
                cmd         = CMD_CLEAR;
                state_n     = ISSUE;
            end
        end else if (accept) begin
            case (state)
                ENTRY_INT: begin
                    if (is_digit) cmd = CMD_INT;
                    else if (is_dot) state_n = ENTRY_FRAC;
                end
                ENTRY_FRAC: begin
                    if (is_digit) cmd = CMD_FRAC;
                end
                OP_WAIT: begin
                    if (is_opkey) begin
                        pending_n = key_to_op(bus.key_code);
                    end else if (is_digit || is_dot) begin
                        cmd     = is_digit ? CMD_INT : CMD_NONE;
                        disp_n  = 1'b0;
                        state_n = is_digit ? ENTRY_INT : ENTRY_FRAC;
                    end else if (is_eq) begin
                        pending_n = OP_ADD;
                        state_n   = RESULT;
                    end
                end
                RESULT: begin
                    if (is_opkey) begin
                        pending_n = key_to_op(bus.key_code);
                        state_n   = OP_WAIT;
                    end else if (is_digit || is_dot) begin
                        // A fresh number after '=' starts a new calculation.
                        alu_rst_n = 1'b1;
                        cmd       = is_digit ? CMD_INT : CMD_NONE;
                        pending_n = OP_ADD;
                        disp_n    = 1'b0;
                        state_n   = is_digit ? ENTRY_INT : ENTRY_FRAC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.en        = state == ISSUE;
    assign bus.err       = state == ERR;
    assign bus.in_bcd    = in_bcd_q;
    assign bus.op        = op_q;
    assign bus.alu_rst   = alu_rst_q;
    assign bus.disp_acc  = disp_q;
    assign bus.entry_bcd = entry;

endmodule

// File: tb/tb_key_entry.sv
// Directed-vector bench for key_entry: key sequences with hand-computed ALU strobes.
module tb_key_entry;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_entry_if #(.W(48)) bus ();

    key_entry dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    int          en_cnt  = 0;
    logic        en_prev = 1'b0;
    logic [2:0]  p_op  [64];
    logic [47:0] p_bcd [64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Records every ALU strobe and confirms it never lasts two cycles.
    always @(negedge clk) begin
        if (bus.en) begin
            chk("en_single_cycle", 64'(en_prev), 64'd0);
            if (en_cnt < 64) begin
                p_op[en_cnt]  = bus.op;
                p_bcd[en_cnt] = bus.in_bcd;
            end
            en_cnt++;
        end
        en_prev = bus.en;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] code);
        for (int i = 0; i < 20 && !bus.key_ready; i++) @(negedge clk);
        if (!bus.key_ready) chk("key_ready_timeout", 64'd0, 64'd1);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 5'd31;
    endtask

    int base;

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 5'd31;
        bus.overflow  = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_key_ready", 64'(bus.key_ready), 64'd1);
        chk("rst_en",        64'(bus.en),        64'd0);
        chk("rst_err",       64'(bus.err),       64'd0);
        chk("rst_disp",      64'(bus.disp_acc),  64'd0);
        chk("rst_entry",     64'(bus.entry_bcd), 64'd0);
        chk("rst_in_bcd",    64'(bus.in_bcd),    64'd0);

        // 12.5 + 3 =
        base = en_cnt;
        press(5'd1); press(5'd2); press(5'd10); press(5'd5);
        chk("entry_12p5", 64'(bus.entry_bcd), 64'h0000_000012_500000);
        press(5'd11); press(5'd3); press(5'd15);
        idle(4);
        chk("s1_en_count", 64'(en_cnt - base), 64'd2);
        chk("s1_op0",  64'(p_op[base]),    64'd0);
        chk("s1_bcd0", 64'(p_bcd[base]),   64'h0000_000012_500000);
        chk("s1_op1",  64'(p_op[base+1]),  64'd0);
        chk("s1_bcd1", 64'(p_bcd[base+1]), 64'h0000_000003_000000);
        chk("s1_disp_acc", 64'(bus.disp_acc), 64'd1);

        // Digit-count limits, repeated '.', invalid code
        press(5'd16);
        for (int i = 0; i < 8; i++) press(5'd7);
        chk("int_limit", 64'(bus.entry_bcd), 64'h0000_777777_000000);
        press(5'd10);
        for (int i = 0; i < 7; i++) press(5'd1);
        chk("frac_limit", 64'(bus.entry_bcd), 64'h0000_777777_111111);
        press(5'd10);
        press(5'd20);
        idle(2);
        chk("dot_invalid_ignored", 64'(bus.entry_bcd), 64'h0000_777777_111111);
        chk("s2_no_en", 64'(en_cnt - base), 64'd2);

        // 5 / 0 = -> error
        press(5'd16);
        base = en_cnt;
        press(5'd5); press(5'd14); press(5'd0); press(5'd15);
        idle(4);
        chk("s3_en_count", 64'(en_cnt - base), 64'd1);
        chk("s3_op0",  64'(p_op[base]),  64'd0);
        chk("s3_bcd0", 64'(p_bcd[base]), 64'h0000_000005_000000);
        chk("s3_err",  64'(bus.err), 64'd1);
        press(5'd3);
        idle(2);
        chk("s3_digit_ignored", 64'(bus.entry_bcd), 64'd0);
        chk("s3_err_held",      64'(bus.err), 64'd1);
        press(5'd16);
        chk("s3_clr_alu_rst", 64'(bus.alu_rst), 64'd1);
        chk("s3_clr_err",     64'(bus.err),     64'd0);
        @(negedge clk);
        chk("s3_alu_rst_one", 64'(bus.alu_rst), 64'd0);

        // 9 * 9 = with ALU overflow
        base = en_cnt;
        press(5'd9); press(5'd13); press(5'd9); press(5'd15);
        chk("s4_issue_en", 64'(bus.en), 64'd1);
        @(negedge clk);
        bus.overflow = 1'b1;
        @(negedge clk);
        chk("s4_ovf_err", 64'(bus.err), 64'd1);
        bus.overflow = 1'b0;
        press(5'd4); press(5'd11);
        idle(4);
        chk("s4_en_count", 64'(en_cnt - base), 64'd2);
        chk("s4_op1",  64'(p_op[base+1]),  64'd2);
        chk("s4_bcd1", 64'(p_bcd[base+1]), 64'h0000_000009_000000);

        // Operator replacement: 4 + - * 2 =
        press(5'd16);
        base = en_cnt;
        press(5'd4); press(5'd11); press(5'd12); press(5'd13); press(5'd2); press(5'd15);
        idle(4);
        chk("s5_en_count", 64'(en_cnt - base), 64'd2);
        chk("s5_op0",  64'(p_op[base]),    64'd0);
        chk("s5_bcd0", 64'(p_bcd[base]),   64'h0000_000004_000000);
        chk("s5_op1",  64'(p_op[base+1]),  64'd2);
        chk("s5_bcd1", 64'(p_bcd[base+1]), 64'h0000_000002_000000);

        // RESULT then digit, then reset during ISSUE
        press(5'd6);
        chk("s6_alu_rst", 64'(bus.alu_rst),   64'd1);
        chk("s6_entry",   64'(bus.entry_bcd), 64'h0000_000006_000000);
        chk("s6_disp",    64'(bus.disp_acc),  64'd0);
        @(negedge clk);
        chk("s6_alu_rst_one", 64'(bus.alu_rst), 64'd0);
        press(5'd11);
        chk("s6_issue_en", 64'(bus.en), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_en",        64'(bus.en),        64'd0);
        chk("rst2_key_ready", 64'(bus.key_ready), 64'd1);
        chk("rst2_in_bcd",    64'(bus.in_bcd),    64'd0);
        chk("rst2_op",        64'(bus.op),        64'd0);
        chk("rst2_disp",      64'(bus.disp_acc),  64'd0);
        chk("rst2_entry",     64'(bus.entry_bcd), 64'd0);
        chk("rst2_alu_rst",   64'(bus.alu_rst),   64'd0);
        rst = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/key_entry.md
Name: key_entry

Overview:
- Front-end operand/operator sequencer for the calculator datapath.
- Converts a stream of decoded keypad codes into fixed-point BCD operands and operation strobes for the downstream ALU (`in_bcd`, `op`, `en`, `alu_rst`).
- Owns chained-operation semantics, divide-by-zero and overflow error handling, and the display source select.

Parameters:
- INT_DIGITS, 6, BCD integer digits of an operand; occupies the upper nibbles.
- FRAC_DIGITS, 6, BCD fraction digits; occupies the lower nibbles. BCD width W = 4*(INT_DIGITS+FRAC_DIGITS) = 48.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle key strobe
- key_code  in  5  0-9 digit, 10 '.', 11 '+', 12 '-', 13 '*', 14 '/', 15 '=', 16 clear; 17-31 ignored
- key_ready  out  1  key accepted when key_valid & key_ready
- overflow  in  1  ALU overflow flag (combinational from accumulator)
- in_bcd  out  W  operand to ALU
- op  out  3  ALU op: 000 add, 001 sub, 010 mul, 011 div
- en  out  1  ALU strobe; ALU acts on rising edge
- alu_rst  out  1  one-cycle accumulator clear
- entry_bcd  out  W  operand being typed (display)
- disp_acc  out  1  1 = display ALU result, 0 = display entry_bcd
- err  out  1  error latched

Behaviour:
- Reset values:
  - en=0, alu_rst=0, op=000, in_bcd=0, entry_bcd=0, disp_acc=0, err=0, key_ready=1.
  - State ENTRY_INT; pending op = add; digit counters 0.
- States: ENTRY_INT, ENTRY_FRAC, OP_WAIT, RESULT, ISSUE, GAP, ERR.
- Digit in ENTRY_INT:
  - entry integer field shifts left one nibble and the digit enters the LS integer nibble.
  - Ignored once INT_DIGITS digits have been taken; leading zeros count.
- '.' in ENTRY_INT: go to ENTRY_FRAC. '.' in ENTRY_FRAC is ignored.
- Digit in ENTRY_FRAC:
  - Written to fraction nibble FRAC_DIGITS-1-fc, then fc++.
  - Ignored when fc == FRAC_DIGITS.
- Operator (+ - * /) in ENTRY_INT or ENTRY_FRAC:
  - Issues the pending op with the current entry, then pending = new op.
  - Divide-by-zero: if the pending op is div and entry == 0, go to ERR with no issue.
- Issue timing, with acceptance in cycle N:
  - N+1: ISSUE; en=1; in_bcd=entry; op=pending.
  - N+2: GAP; en=0; in_bcd and op held. If overflow=1, go to ERR; else go to the next state.
  - N+3: key_ready=1.
  - key_ready=0 in ISSUE and GAP.
- After an operator issue: entry cleared, counters cleared, state OP_WAIT, disp_acc=1.
- In OP_WAIT:
  - Operator replaces pending with no issue.
  - Digit or '.' starts a new entry: ENTRY_INT or ENTRY_FRAC, disp_acc=0.
  - '=' sets pending=add and goes to RESULT with no issue.
- '=' in ENTRY_INT or ENTRY_FRAC: issues pending (same timing, same div-zero check), then pending=add, state RESULT, disp_acc=1.
- In RESULT:
  - Operator sets pending=op, go to OP_WAIT (accumulator keeps the result; no issue).
  - Digit or '.': alu_rst=1 for one cycle (N+1), entry starts with that key, pending=add, disp_acc=0.
  - '=' is ignored.
- Clear (any state where key_ready=1, including ERR):
  - alu_rst=1 for one cycle; entry and counters cleared; pending=add; err=0; state ENTRY_INT; disp_acc=0.
- ERR: err=1; all keys except clear ignored; en is never raised.
- Invalid codes (17-31) are ignored in all states.
- en never stays high for more than 1 cycle; it is always followed by at least one low cycle.
- rst in any state, including mid-ISSUE, restores the reset values on the next edge; en drops immediately.
- Simultaneous key_valid during ISSUE/GAP: the key is dropped; the upstream must honour key_ready.

Decomposition:
- Package calc_pkg holds:
  - key code constants;
  - ALU op encodings (shared with the ALU);
  - state enum;
  - INT_DIGITS / FRAC_DIGITS defaults.
- One natural sub-module: bcd_entry_reg. It holds the entry register, the digit counters, and the shift/insert logic, with commands clear/int_digit/frac_digit.

Test Plan:
- Keys 1,2,'.',5,'+',3,'=' -> first en pulse: op=000, in_bcd=48'h000012_500000. Second en pulse: op=000, in_bcd=48'h000003_000000. Ends in RESULT with disp_acc=1.
- Keys 7 typed eight times -> entry_bcd=48'h777777_000000; the 7th and 8th digits are ignored. Then '.' then 1 seven times -> 48'h777777_111111.
- Keys 5,'/',0,'=' -> one en pulse (add 5). Then err=1 with no second en pulse. Digit 3 ignored. Clear -> alu_rst pulse, err=0.
- Keys 9,'*', then force overflow=1 during GAP of the second issue ('*' 9 '=') -> err=1 in the next cycle; en low thereafter.
- Keys 4,'+','-','*',2,'=' -> exactly two en pulses: add 4, then op=010 with in_bcd=48'h000002_000000.
- RESULT then digit 6 -> alu_rst=1 for one cycle, entry_bcd=48'h000006_000000. Asserting rst during ISSUE -> en=0 and all outputs at reset values next cycle.
